serial_sub_ctrl: RTL and testbench

SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

---
 rtl/serial_pkg.sv | 15 +
 rtl/borrow_flipflop.sv | 16 +
 rtl/serial_sub_ctrl.sv | 108 ++++++++++
 tb/tb_serial_sub_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and the
// helper that sizes the bit counter.
`timescale 1ns/1ps
package serial_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_FIN   = 2'd2;

   // Bits needed to count from 0 up to and including width.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/borrow_flipflop.sv
// Single borrow storage bit with asynchronous active-high clear.
`timescale 1ns/1ps
module borrow_flipflop (
   input  logic CLK,
   input  logic R,
   input  logic D,
   output logic Q
);

   // Capture D each rising edge; R clears immediately.
   always_ff @(posedge CLK or posedge R) begin
      if (R) Q <= 1'b0;
      else   Q <= D;
   end

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: A-B computed LSB first, one bit per SHIFT cycle,
// with the borrow carried between cycles in a dedicated flop.
`timescale 1ns/1ps
module serial_sub_ctrl
   import serial_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             R,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] DIFF,
   output logic             BOUT
);

   localparam int CW = cnt_width(WIDTH);
   // Counter value seen on the edge that completes the last bit.
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             bq;
   logic             b_d;
   logic             d_bit;
   logic             bnext;

   // Full-subtractor on the current LSBs and the stored borrow.
   always_comb begin
      d_bit = sa_q[0] ^ sb_q[0] ^ bq;
      bnext = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bq);
   end

   // Next-state logic: load on accept, shift/accumulate in SHIFT, hold otherwise.
   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      b_d     = bq;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               sa_d    = A;
               sb_d    = B;
               cnt_d   = '0;
               b_d     = 1'b0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            sa_d             = sa_q >> 1;
            sb_d             = sb_q >> 1;
            res_d            = res_q >> 1;
            res_d[WIDTH-1]   = d_bit;
            b_d              = bnext;
            cnt_d            = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) state_d = ST_FIN;
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers, cleared at once by R.
   always_ff @(posedge CLK or posedge R) begin
      if (R) begin
         state_q <= ST_IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
      end
   end

   borrow_flipflop u_borrow (
      .CLK (CLK),
      .R   (R),
      .D   (b_d),
      .Q   (bq)
   );

   // Status and result outputs straight from registered state.
   always_comb begin
      BUSY = (state_q == ST_SHIFT) || (state_q == ST_FIN);
      DONE = (state_q == ST_FIN);
      DIFF = res_q;
      BOUT = bq;
   end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl: WIDTH=8 instance against a cycle-count model,
// plus a WIDTH=1 instance exercised with hand-computed cases.
`timescale 1ns/1ps
module tb_serial_sub_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, bout8;
   logic [7:0] diff8;

   logic       start1 = 1'b0;
   logic [0:0] a1 = '0, b1 = '0;
   logic       busy1, done1, bout1;
   logic [0:0] diff1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   serial_sub_ctrl #(.WIDTH(8)) dut8 (
      .CLK(clk), .R(rst), .START(start8), .A(a8), .B(b8),
      .BUSY(busy8), .DONE(done8), .DIFF(diff8), .BOUT(bout8)
   );

   serial_sub_ctrl #(.WIDTH(1)) dut1 (
      .CLK(clk), .R(rst), .START(start1), .A(a1), .B(b1),
      .BUSY(busy1), .DONE(done1), .DIFF(diff1), .BOUT(bout1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model for the 8-bit instance: cycles remaining in the
   // current operation (0 = idle), pending result, and last completed result.
   int         rem = 0;
   logic [7:0] pend_diff = '0, held_diff = '0;
   logic       pend_bout = 1'b0, held_bout = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rem = 0; held_diff = '0; held_bout = 1'b0;
      end else if (rem == 0) begin
         if (start8) begin
            rem       = 8 + 1;
            pend_diff = a8 - b8;
            pend_bout = (a8 < b8);
         end
      end else begin
         rem = rem - 1;
         if (rem == 0) begin
            held_diff = pend_diff;
            held_bout = pend_bout;
         end
      end
   end

   // Compare the 8-bit instance with the model every cycle.
   always @(negedge clk) begin
      check("busy8", {31'b0, busy8}, {31'b0, rem != 0});
      check("done8", {31'b0, done8}, {31'b0, rem == 1});
      if (rem == 1) begin
         check("diff8_done", {24'b0, diff8}, {24'b0, pend_diff});
         check("bout8_done", {31'b0, bout8}, {31'b0, pend_bout});
      end else if (rem == 0) begin
         check("diff8_hold", {24'b0, diff8}, {24'b0, held_diff});
         check("bout8_hold", {31'b0, bout8}, {31'b0, held_bout});
      end
   end

   task automatic run8(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_d, input logic exp_b);
      int n;
      @(negedge clk); a8 = a; b8 = b; start8 = 1'b1;
      @(negedge clk); start8 = 1'b0; a8 = ~a; b8 = 8'($urandom);
      n = 0;
      while (!done8 && n < 20) begin
         @(negedge clk); n++;
         a8 = 8'($urandom); b8 = 8'($urandom);
      end
      check("latency8", n, 8);
      check("lit_diff8", {24'b0, diff8}, {24'b0, exp_d});
      check("lit_bout8", {31'b0, bout8}, {31'b0, exp_b});
      $display("op8 A=%02h B=%02h -> DIFF=%02h BOUT=%0d after %0d cycles", a, b, diff8, bout8, n);
   endtask

   task automatic run1(input logic a, input logic b, input logic exp_d, input logic exp_b);
      int n;
      @(negedge clk); a1 = a; b1 = b; start1 = 1'b1;
      @(negedge clk); start1 = 1'b0; a1 = ~a; b1 = ~b;
      check("busy1", {31'b0, busy1}, 32'd1);
      n = 0;
      while (!done1 && n < 5) begin
         @(negedge clk); n++;
      end
      check("latency1", n, 1);
      check("lit_diff1", {31'b0, diff1}, {31'b0, exp_d});
      check("lit_bout1", {31'b0, bout1}, {31'b0, exp_b});
      $display("op1 A=%0d B=%0d -> DIFF=%0d BOUT=%0d after %0d cycles", a, b, diff1, bout1, n);
      @(negedge clk);
   endtask

   initial begin
      int dones[$];
      int cyc;

      // Reset state
      #2;
      check("rst_busy", {31'b0, busy8}, 32'd0);
      check("rst_done", {31'b0, done8}, 32'd0);
      check("rst_diff", {24'b0, diff8}, 32'd0);
      check("rst_bout", {31'b0, bout8}, 32'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Directed 8-bit cases
      run8(8'h05, 8'h03, 8'h02, 1'b0);
      run8(8'h03, 8'h05, 8'hFE, 1'b1);
      run8(8'h00, 8'h00, 8'h00, 1'b0);
      run8(8'h00, 8'h01, 8'hFF, 1'b1);
      @(negedge clk);

      // Randomized traffic, START often asserted while busy
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         start8 = ($urandom_range(3) == 0);
         a8 = 8'($urandom); b8 = 8'($urandom);
      end
      start8 = 1'b0;
      for (int i = 0; i < 12; i++) @(negedge clk);

      // START held high: accepts every WIDTH+2 cycles
      start8 = 1'b1;
      cyc = 0;
      for (int i = 0; i < 45; i++) begin
         a8 = 8'($urandom); b8 = 8'($urandom);
         @(negedge clk); cyc++;
         if (done8) dones.push_back(cyc);
      end
      start8 = 1'b0;
      check("hold_done_count", dones.size(), 4);
      for (int i = 1; i < dones.size(); i++)
         check("hold_period", dones[i] - dones[i-1], 10);
      $display("held START: %0d DONE pulses observed", dones.size());
      for (int i = 0; i < 12; i++) @(negedge clk);

      // Reset during the third SHIFT cycle
      a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
      @(negedge clk); start8 = 1'b0;
      @(posedge clk); @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("midrst_busy", {31'b0, busy8}, 32'd0);
      check("midrst_diff", {24'b0, diff8}, 32'd0);
      check("midrst_done", {31'b0, done8}, 32'd0);
      #1 rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("no_done_after_rst", {31'b0, done8}, 32'd0);
      end
      $display("reset mid-operation: abandoned");
      run8(8'h80, 8'h7F, 8'h01, 1'b0);

      // WIDTH=1 instance
      run1(1'b0, 1'b0, 1'b0, 1'b0);
      run1(1'b0, 1'b1, 1'b1, 1'b1);
      run1(1'b1, 1'b0, 1'b1, 1'b0);
      run1(1'b1, 1'b1, 1'b0, 1'b0);

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
